// File: rtl/div_ctrl_pkg.sv
// Shared constants, state encoding and small helpers for the RV32M divide controller.
package div_ctrl_pkg;

  localparam int WORD_WIDTH = 32;

  // Instruction-level operation: bit0 = unsigned, bit1 = remainder.
  localparam logic [1:0] MD_OP_DIV  = 2'b00;
  localparam logic [1:0] MD_OP_DIVU = 2'b01;
  localparam logic [1:0] MD_OP_REM  = 2'b10;
  localparam logic [1:0] MD_OP_REMU = 2'b11;

  // Divider opcode: signed or unsigned division.
  localparam logic DIV_OP_DIV  = 1'b0;
  localparam logic DIV_OP_DIVU = 1'b1;

  typedef enum logic [1:0] {
    DIVC_IDLE  = 2'd0,
    DIVC_START = 2'd1,
    DIVC_BUSY  = 2'd2,
    DIVC_DONE  = 2'd3
  } divc_state_e;

  // Operand pairs whose result the divider produces in the start cycle.
  function automatic logic is_special(input logic [WORD_WIDTH-1:0] a,
                                      input logic [WORD_WIDTH-1:0] b,
                                      input logic                  uns);
    return (b == '0) ||
           (!uns && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
  endfunction

  // Number of significant bits in v (0 for v == 0); sets the iteration count.
  function automatic logic [5:0] sig_bits(input logic [WORD_WIDTH-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (v[i]) n = 6'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/div_ctrl_div.sv
// Iterative radix-2 restoring divider. Special operand pairs (x/0, signed
// overflow) are answered combinationally in the start cycle; other operands
// iterate once per significant dividend bit, so small dividends finish early.
// A new start always restarts the unit, abandoning any operation in flight.
module div_ctrl_div
  import div_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  div_start,
  input  logic                  div_opcode,
  input  logic [WORD_WIDTH-1:0] div_divident,
  input  logic [WORD_WIDTH-1:0] div_divisor,
  output logic [WORD_WIDTH-1:0] div_quotient,
  output logic [WORD_WIDTH-1:0] div_remainder,
  output logic                  div_finish
);

  logic                  busy_q, busy_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] rem_q, rem_d;
  logic [WORD_WIDTH-1:0] quo_q, quo_d;
  logic [WORD_WIDTH-1:0] dvs_q, dvs_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  fin_q, fin_d;
  logic [WORD_WIDTH-1:0] res_quo_q, res_quo_d;
  logic [WORD_WIDTH-1:0] res_rem_q, res_rem_d;

  logic                  uns;
  logic                  special;
  logic [WORD_WIDTH-1:0] abs_a, abs_b;
  logic [5:0]            nbits;
  logic [WORD_WIDTH:0]   trial;
  logic                  ge;
  logic [WORD_WIDTH-1:0] rem_step, quo_step;
  logic [WORD_WIDTH-1:0] sp_quo, sp_rem;

  // Operand conditioning, one restoring step, and next-state selection.
  always_comb begin
    uns      = (div_opcode == DIV_OP_DIVU);
    special  = is_special(div_divident, div_divisor, uns);
    abs_a    = (!uns && div_divident[WORD_WIDTH-1]) ? -div_divident : div_divident;
    abs_b    = (!uns && div_divisor[WORD_WIDTH-1])  ? -div_divisor  : div_divisor;
    nbits    = sig_bits(abs_a);
    sp_quo   = (div_divisor == '0) ? 32'hFFFF_FFFF : 32'h8000_0000;
    sp_rem   = (div_divisor == '0) ? div_divident  : '0;

    // Shift the next dividend bit into the partial remainder and try to subtract.
    trial    = {rem_q, quo_q[WORD_WIDTH-1]} - {1'b0, dvs_q};
    ge       = !trial[WORD_WIDTH];
    rem_step = ge ? trial[WORD_WIDTH-1:0] : {rem_q[WORD_WIDTH-2:0], quo_q[WORD_WIDTH-1]};
    quo_step = {quo_q[WORD_WIDTH-2:0], ge};

    busy_d    = busy_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    fin_d     = 1'b0;
    res_quo_d = res_quo_q;
    res_rem_d = res_rem_q;

    if (div_start) begin
      if (special) begin
        busy_d = 1'b0;
      end else if (nbits == 6'd0) begin
        // Zero dividend with nonzero divisor: q = 0, r = 0, no iterations needed.
        busy_d    = 1'b0;
        fin_d     = 1'b1;
        res_quo_d = '0;
        res_rem_d = '0;
      end else begin
        busy_d    = 1'b1;
        cnt_d     = nbits;
        rem_d     = '0;
        // Left-align the dividend so leading zeros are skipped.
        quo_d     = abs_a << (6'd32 - nbits);
        dvs_d     = abs_b;
        neg_quo_d = !uns && (div_divident[WORD_WIDTH-1] ^ div_divisor[WORD_WIDTH-1]);
        neg_rem_d = !uns && div_divident[WORD_WIDTH-1];
      end
    end else if (busy_q) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q - 6'd1;
      if (cnt_q == 6'd1) begin
        busy_d    = 1'b0;
        fin_d     = 1'b1;
        res_quo_d = neg_quo_q ? -quo_step : quo_step;
        res_rem_d = neg_rem_q ? -rem_step : rem_step;
      end
    end
  end

  // Datapath and sequencing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      fin_q     <= 1'b0;
      res_quo_q <= '0;
      res_rem_q <= '0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      fin_q     <= fin_d;
      res_quo_q <= res_quo_d;
      res_rem_q <= res_rem_d;
    end
  end

  assign div_finish    = (div_start && special) || fin_q;
  assign div_quotient  = (div_start && special) ? sp_quo : res_quo_q;
  assign div_remainder = (div_start && special) ? sp_rem : res_rem_q;

endmodule

// File: rtl/div_ctrl.sv
// Sequencing controller for DIV/DIVU/REM/REMU: latches operands, starts the
// divider, stalls the pipeline until it finishes and presents the selected
// result to writeback for one cycle. A one-entry operand cache lets a
// DIV/REM pair on identical operands complete without re-running the divider.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_md_req,
  input  logic [1:0]            ex_md_op,
  input  logic [WORD_WIDTH-1:0] ex_rs1_data,
  input  logic [WORD_WIDTH-1:0] ex_rs2_data,
  input  logic [4:0]            ex_rd_addr,
  input  logic                  ex_flush,
  output logic                  div_stall,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd_addr,
  output logic [WORD_WIDTH-1:0] wb_data
);

  divc_state_e           state_q, state_d;
  logic [WORD_WIDTH-1:0] rs1_q, rs1_d;
  logic [WORD_WIDTH-1:0] rs2_q, rs2_d;
  logic [1:0]            op_q, op_d;
  logic [4:0]            rd_q, rd_d;
  logic [4:0]            wb_rd_addr_q, wb_rd_addr_d;
  logic [WORD_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                  cache_valid_q, cache_valid_d;
  logic [WORD_WIDTH-1:0] cache_rs1_q, cache_rs1_d;
  logic [WORD_WIDTH-1:0] cache_rs2_q, cache_rs2_d;
  logic                  cache_uns_q, cache_uns_d;
  logic [WORD_WIDTH-1:0] cache_quo_q, cache_quo_d;
  logic [WORD_WIDTH-1:0] cache_rem_q, cache_rem_d;

  logic                  div_start;
  logic                  div_opcode;
  logic [WORD_WIDTH-1:0] div_quotient;
  logic [WORD_WIDTH-1:0] div_remainder;
  logic                  div_finish;

  logic                  accept;
  logic                  cache_hit;
  logic                  capture;

  div_ctrl_div u_div (
    .clk           (clk),
    .rst_n         (rst_n),
    .div_start     (div_start),
    .div_opcode    (div_opcode),
    .div_divident  (rs1_q),
    .div_divisor   (rs2_q),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .div_finish    (div_finish)
  );

  assign div_start  = (state_q == DIVC_START);
  assign div_opcode = op_q[0] ? DIV_OP_DIVU : DIV_OP_DIV;

  // Next-state, operand latching, result capture and cache update.
  always_comb begin
    accept    = (state_q == DIVC_IDLE) && ex_md_req && !ex_flush;
    // Cache matches on operand values and signedness; REM vs DIV may differ.
    cache_hit = cache_valid_q && (ex_rs1_data == cache_rs1_q) &&
                (ex_rs2_data == cache_rs2_q) && (ex_md_op[0] == cache_uns_q);
    capture   = 1'b0;

    state_d       = state_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    op_d          = op_q;
    rd_d          = rd_q;
    wb_rd_addr_d  = wb_rd_addr_q;
    wb_data_d     = wb_data_q;
    cache_valid_d = cache_valid_q;
    cache_rs1_d   = cache_rs1_q;
    cache_rs2_d   = cache_rs2_q;
    cache_uns_d   = cache_uns_q;
    cache_quo_d   = cache_quo_q;
    cache_rem_d   = cache_rem_q;

    case (state_q)
      DIVC_IDLE: begin
        if (accept) begin
          if (cache_hit) begin
            wb_data_d    = ex_md_op[1] ? cache_rem_q : cache_quo_q;
            wb_rd_addr_d = ex_rd_addr;
            state_d      = DIVC_DONE;
          end else begin
            rs1_d   = ex_rs1_data;
            rs2_d   = ex_rs2_data;
            op_d    = ex_md_op;
            rd_d    = ex_rd_addr;
            state_d = DIVC_START;
          end
        end
      end
      DIVC_START: begin
        if (ex_flush) begin
          state_d = DIVC_IDLE;
        end else if (is_special(rs1_q, rs2_q, op_q[0]) && div_finish) begin
          // Only trust a finish here for operands the divider resolves at once;
          // any other finish is a leftover from an aborted operation.
          capture = 1'b1;
          state_d = DIVC_DONE;
        end else begin
          state_d = DIVC_BUSY;
        end
      end
      DIVC_BUSY: begin
        if (ex_flush) begin
          state_d = DIVC_IDLE;
        end else if (div_finish) begin
          capture = 1'b1;
          state_d = DIVC_DONE;
        end
      end
      default: begin
        state_d = DIVC_IDLE;
      end
    endcase

    if (capture) begin
      wb_data_d     = op_q[1] ? div_remainder : div_quotient;
      wb_rd_addr_d  = rd_q;
      cache_valid_d = 1'b1;
      cache_rs1_d   = rs1_q;
      cache_rs2_d   = rs2_q;
      cache_uns_d   = op_q[0];
      cache_quo_d   = div_quotient;
      cache_rem_d   = div_remainder;
    end
  end

  // Controller state machine and its registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= DIVC_IDLE;
      rs1_q         <= '0;
      rs2_q         <= '0;
      op_q          <= '0;
      rd_q          <= '0;
      wb_rd_addr_q  <= '0;
      wb_data_q     <= '0;
      cache_valid_q <= 1'b0;
      cache_rs1_q   <= '0;
      cache_rs2_q   <= '0;
      cache_uns_q   <= 1'b0;
      cache_quo_q   <= '0;
      cache_rem_q   <= '0;
    end else begin
      state_q       <= state_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      op_q          <= op_d;
      rd_q          <= rd_d;
      wb_rd_addr_q  <= wb_rd_addr_d;
      wb_data_q     <= wb_data_d;
      cache_valid_q <= cache_valid_d;
      cache_rs1_q   <= cache_rs1_d;
      cache_rs2_q   <= cache_rs2_d;
      cache_uns_q   <= cache_uns_d;
      cache_quo_q   <= cache_quo_d;
      cache_rem_q   <= cache_rem_d;
    end
  end

  // Stall covers the acceptance cycle and the wait; DONE lets the pipeline advance.
  assign div_stall  = accept || (state_q == DIVC_START) || (state_q == DIVC_BUSY);
  // A flush during DONE kills the writeback of the retiring instruction.
  assign wb_valid   = (state_q == DIVC_DONE) && !ex_flush;
  assign wb_rd_addr = wb_rd_addr_q;
  assign wb_data    = wb_data_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed and randomized checks of div_ctrl against an arithmetic reference
// model with a one-entry operand cache model.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ex_md_req = 1'b0;
  logic [1:0]  ex_md_op = 2'b00;
  logic [31:0] ex_rs1_data = '0;
  logic [31:0] ex_rs2_data = '0;
  logic [4:0]  ex_rd_addr = '0;
  logic        ex_flush = 1'b0;
  logic        div_stall;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;

  // Reference cache model.
  bit          cv = 1'b0;
  logic [31:0] ca = '0;
  logic [31:0] cb = '0;
  bit          cu = 1'b0;

  div_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_md_req   (ex_md_req),
    .ex_md_op    (ex_md_op),
    .ex_rs1_data (ex_rs1_data),
    .ex_rs2_data (ex_rs2_data),
    .ex_rd_addr  (ex_rd_addr),
    .ex_flush    (ex_flush),
    .div_stall   (div_stall),
    .wb_valid    (wb_valid),
    .wb_rd_addr  (wb_rd_addr),
    .wb_data     (wb_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dut.div_start) start_cnt++;

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return op[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at 1 time unit after a rising edge; returns at the same phase of
  // the cycle after DONE with the request dropped.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string tag);
    logic [31:0] exp;
    bit hit, sp;
    int k, s0;
    exp = ref_res(op, a, b);
    hit = cv && (a == ca) && (b == cb) && (op[0] == cu);
    sp  = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    s0  = start_cnt;
    ex_md_req = 1'b1; ex_md_op = op; ex_rs1_data = a; ex_rs2_data = b; ex_rd_addr = rd;
    #1;
    chk({tag, " accept_stall"}, 32'(div_stall), 32'd1);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!wb_valid && k < 60);
    chk({tag, " wb_valid"}, 32'(wb_valid), 32'd1);
    chk({tag, " wb_data"}, wb_data, exp);
    chk({tag, " wb_rd_addr"}, 32'(wb_rd_addr), 32'(rd));
    chk({tag, " done_stall"}, 32'(div_stall), 32'd0);
    if (hit) begin
      chk({tag, " hit_latency"}, 32'(k), 32'd1);
      chk({tag, " hit_no_start"}, 32'(start_cnt - s0), 32'd0);
    end else if (sp) begin
      chk({tag, " special_latency"}, 32'(k), 32'd2);
    end else begin
      chk({tag, " miss_latency_in_range"}, 32'(k >= 3 && k <= 35), 32'd1);
    end
    $display("[TB] %s op=%0d a=%h b=%h rd=%0d -> data=%h exp=%h lat=%0d hit=%0d",
             tag, op, a, b, rd, wb_data, exp, k, hit);
    cv = 1'b1; ca = a; cb = b; cu = op[0];
    ex_md_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] ra, rb, la, lb;
    logic [1:0]  rop;
    int          cat;

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    chk("reset stall", 32'(div_stall), 32'd0);
    chk("reset wb_valid", 32'(wb_valid), 32'd0);
    chk("reset wb_rd_addr", 32'(wb_rd_addr), 32'd0);
    chk("reset wb_data", wb_data, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(MD_OP_DIV,  32'd7, 32'd2, 5'd5, "div7_2");
    run_op(MD_OP_REM,  32'd7, 32'd2, 5'd6, "rem7_2_hit");
    run_op(MD_OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd7, "div_m7_2");
    run_op(MD_OP_REMU, 32'hFFFF_FFF9, 32'd2, 5'd8, "remu_fff9_2");
    run_op(MD_OP_DIVU, 32'd5, 32'd0, 5'd1, "divu5_0");
    run_op(MD_OP_REM,  32'd5, 32'd0, 5'd2, "rem5_0");
    run_op(MD_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd3, "div_ovf");
    run_op(MD_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd4, "rem_ovf_hit");
    run_op(MD_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd0, "divu_full_rd0");

    // Flush two cycles into BUSY, then issue a new op immediately.
    ex_md_req = 1'b1; ex_md_op = MD_OP_DIV; ex_rs1_data = 32'h7FFF_FFFF;
    ex_rs2_data = 32'd3; ex_rd_addr = 5'd12;
    repeat (3) begin @(posedge clk); #1; end
    ex_flush = 1'b1;
    #1;
    chk("flush wb_valid", 32'(wb_valid), 32'd0);
    chk("flush busy_stall", 32'(div_stall), 32'd1);
    @(posedge clk); #1;
    ex_flush = 1'b0; ex_md_req = 1'b0;
    #1;
    chk("after_flush stall", 32'(div_stall), 32'd0);
    chk("after_flush wb_valid", 32'(wb_valid), 32'd0);
    run_op(MD_OP_DIVU, 32'd100, 32'd7, 5'd9, "divu100_7_after_flush");

    // Reset in the middle of BUSY.
    ex_md_req = 1'b1; ex_md_op = MD_OP_DIV; ex_rs1_data = 32'h1234_5678;
    ex_rs2_data = 32'd3; ex_rd_addr = 5'd13;
    repeat (2) begin @(posedge clk); #1; end
    ex_md_req = 1'b0; rst_n = 1'b0;
    #1;
    chk("midreset stall", 32'(div_stall), 32'd0);
    chk("midreset wb_valid", 32'(wb_valid), 32'd0);
    chk("midreset wb_rd_addr", 32'(wb_rd_addr), 32'd0);
    chk("midreset wb_data", wb_data, 32'd0);
    chk("midreset state", 32'(dut.state_q), 32'(DIVC_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    cv = 1'b0;
    @(posedge clk); #1;
    run_op(MD_OP_DIV, 32'd7, 32'd2, 5'd5, "div7_2_after_reset");

    // Randomized operations; category 0 reuses the previous operands to hit the cache.
    la = 32'd7; lb = 32'd2;
    for (int i = 0; i < 40; i++) begin
      cat = $urandom_range(0, 5);
      rop = 2'($urandom_range(0, 3));
      case (cat)
        0: begin ra = la; rb = lb; end
        1: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
        2: begin ra = $urandom; rb = $urandom; end
        3: begin ra = $urandom; rb = 32'd0; end
        4: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: begin ra = $urandom; rb = 32'($urandom_range(1, 20)); end
      endcase
      if ($urandom_range(0, 1) == 1) rb = -rb;
      run_op(rop, ra, rb, 5'($urandom_range(0, 31)), $sformatf("rand%0d", i));
      la = ra; lb = rb;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
